// File: rtl/dtu_pkg.sv
// Shared defaults and FSM encoding for the DNA-symbol transmit unit.
package dtu_pkg;

  localparam int unsigned DTU_DIN_W     = 32;
  localparam int unsigned DTU_SYM_W     = 2;
  localparam int unsigned SYMS_PER_WORD = DTU_DIN_W / DTU_SYM_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dtu_state_e;

endpackage

// File: rtl/dtu_serializer.sv
// Word shifter: emits one SYM_W-bit symbol per enabled cycle, LSB first.
module dtu_serializer
  import dtu_pkg::*;
#(
  parameter int unsigned DIN_W = DTU_DIN_W,
  parameter int unsigned SYM_W = DTU_SYM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             run,
  input  logic [DIN_W-1:0] word,
  output logic [SYM_W-1:0] dout,
  output logic             dout_valid,
  output logic             last_c
);

  localparam int unsigned N_SYM = DIN_W / SYM_W;
  localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

  logic [DIN_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;

  assign last_c     = (idx_q == IDX_W'(N_SYM - 1));
  assign dout       = dout_q;
  assign dout_valid = valid_q;

  // Next symbol: load a fresh word, advance within the word, or go quiet.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (en) begin
      if (load) begin
        shift_d = word >> SYM_W;
        dout_d  = word[SYM_W-1:0];
        idx_d   = '0;
        valid_d = 1'b1;
      end else if (run && !last_c) begin
        shift_d = shift_q >> SYM_W;
        dout_d  = shift_q[SYM_W-1:0];
        idx_d   = idx_q + IDX_W'(1);
        valid_d = 1'b1;
      end else begin
        idx_d = '0;
      end
    end
  end

  // Shifter, index and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/dtu_core.sv
// DNA-symbol transmit unit: one-word input buffer, IDLE/RUN FSM, serializer.
// Optional symbol counter output sym_count enabled by defining DTU_STATS_EN.
module dtu_core
  import dtu_pkg::*;
#(
  parameter int unsigned DIN_W = DTU_DIN_W,
  parameter int unsigned SYM_W = DTU_SYM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic [SYM_W-1:0] dout,
  output logic             dout_valid,
  output logic             ready
`ifdef DTU_STATS_EN
  ,
  output logic [31:0]      sym_count
`endif
);

  dtu_state_e       state_q, state_d;
  logic [DIN_W-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             ready_q;
  logic             accept_c;
  logic             load_c;
  logic             last_c;

  assign accept_c = en && ready_q && din_valid;
  assign ready    = ready_q;

  // Next state, buffer drain into the shifter and buffer fill from din.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load_c     = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (buf_full_q) begin
            load_c     = 1'b1;
            buf_full_d = 1'b0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_c) begin
            if (buf_full_q) begin
              load_c     = 1'b1;
              buf_full_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept_c) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end
  end

  // State, buffer and ready registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= en && !buf_full_d;
    end
  end

  dtu_serializer #(
    .DIN_W (DIN_W),
    .SYM_W (SYM_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load_c),
    .run        (state_q == ST_RUN),
    .word       (buf_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last_c     (last_c)
  );

`ifdef DTU_STATS_EN
  logic [31:0] cnt_q;

  // Count symbols presented on dout; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (dout_valid) cnt_q <= cnt_q + 32'd1;
  end

  assign sym_count = cnt_q;
`endif

endmodule

// File: tb/tb_dtu_core.sv
// Directed self-checking bench for dtu_core (default 32-bit word, 2-bit symbols).
module tb_dtu_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic        din_valid;
  logic [1:0]  dout;
  logic        dout_valid;
  logic        ready;
`ifdef DTU_STATS_EN
  logic [31:0] sym_count;
`endif

  int checks = 0;
  int errors = 0;

  dtu_core dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ready      (ready)
`ifdef DTU_STATS_EN
    ,
    .sym_count  (sym_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one word for one edge.
  task automatic send(input logic [31:0] w);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(ready), 32'd1);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Expect symbols lo..hi of w on consecutive cycles.
  task automatic expect_range(input string tag, input logic [31:0] w, input int lo, input int hi);
    logic [1:0] s;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      s = w[2*i +: 2];
      chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk({tag, "_sym"}, 32'(dout), 32'(s));
    end
  endtask

  // Back-to-back pair; optionally offer a junk word while the buffer is full.
  task automatic two_words(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit junk);
    send(a);
    expect_range({tag, "_a"}, a, 0, 0);
    chk({tag, "_ready_hi"}, 32'(ready), 32'd1);
    din       = b;
    din_valid = 1'b1;
    expect_range({tag, "_a"}, a, 1, 1);
    chk({tag, "_ready_lo"}, 32'(ready), 32'd0);
    din       = 32'hAAAA_AAAA;
    din_valid = junk;
    for (int i = 2; i <= 15; i++) begin
      expect_range({tag, "_a"}, a, i, i);
      chk({tag, "_full_ready"}, 32'(ready), 32'd0);
      din_valid = junk && (i < 8);
    end
    din_valid = 1'b0;
    expect_range({tag, "_b"}, b, 0, 15);
    @(negedge clk);
    chk({tag, "_end_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_end_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_valid", 32'(dout_valid), 32'd0);

    // Single word 0xE4E4E4E4 -> 0,1,2,3 x4 then quiet
    send(32'hE4E4_E4E4);
    expect_range("e4", 32'hE4E4_E4E4, 0, 15);
    @(negedge clk);
    chk("e4_end_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    chk("e4_idle_valid", 32'(dout_valid), 32'd0);

    // Back-to-back zeros then ones with no gap
    two_words("b2b", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    // Word offered while buffer is full is ignored
    two_words("junk", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // Enable pause after the 4th symbol of 0x1B1B1B1B
    send(32'h1B1B_1B1B);
    expect_range("pause", 32'h1B1B_1B1B, 0, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_valid", 32'(dout_valid), 32'd0);
      chk("pause_ready", 32'(ready), 32'd0);
      chk("pause_dout_hold", 32'(dout), 32'd0);
    end
    en = 1'b1;
    expect_range("resume", 32'h1B1B_1B1B, 4, 15);
    @(negedge clk);
    chk("resume_end_valid", 32'(dout_valid), 32'd0);
    chk("resume_ready", 32'(ready), 32'd1);

    // Reset at the 8th symbol with a second word buffered
    send(32'h3C3C_3C3C);
    expect_range("mid", 32'h3C3C_3C3C, 0, 0);
    din       = 32'h5555_5555;
    din_valid = 1'b1;
    expect_range("mid", 32'h3C3C_3C3C, 1, 1);
    din_valid = 1'b0;
    expect_range("mid", 32'h3C3C_3C3C, 2, 7);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("after_rst_quiet", 32'(dout_valid), 32'd0);
    end
    chk("after_rst_ready", 32'(ready), 32'd1);

    // Three full words after reset
    send(32'hE4E4_E4E4);
    expect_range("w1", 32'hE4E4_E4E4, 0, 15);
    send(32'h0F0F_F0F0);
    expect_range("w2", 32'h0F0F_F0F0, 0, 15);
    send(32'hC6C6_396C);
    expect_range("w3", 32'hC6C6_396C, 0, 15);
    @(negedge clk);
    chk("w3_end_valid", 32'(dout_valid), 32'd0);
`ifdef DTU_STATS_EN
    chk("sym_count", sym_count, 32'd48);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
